// File: rtl/dac_channel_scheduler_if.sv
// DAC scheduler bus: per-channel requests and words in,
// shared serial DAC pins, load strobes and acks out.
interface dac_channel_scheduler_if #(
  parameter int N_CH = 16,
  parameter int DW   = 16
);
  logic [N_CH-1:0]    req;
  logic [N_CH*DW-1:0] wr_data;
  logic [N_CH-1:0]    ack;
  logic               busy;
  logic               dac_cs;
  logic               sck;
  logic [N_CH-1:0]    sdi;
  logic [N_CH-1:0]    ldac;

  modport master (
    output req, wr_data,
    input  ack, busy, dac_cs, sck, sdi, ldac
  );

  modport slave (
    input  req, wr_data,
    output ack, busy, dac_cs, sck, sdi, ldac
  );
endinterface

// File: rtl/dac_channel_scheduler.sv
// Round-robin scheduler sharing one serial DAC bus (cs/sck)
// across N_CH channels, each with its own sdi and ldac.
module dac_channel_scheduler #(
  parameter int N_CH    = 16,
  parameter int DW      = 16,
  parameter int CLK_DIV = 4,
  parameter int LDAC_W  = 2
) (
  input  logic clk,
  input  logic rst,
  dac_channel_scheduler_if.slave bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W = (DW > 1) ? $clog2(DW) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW_W  = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);
  localparam logic [LW_W-1:0]  LW_LAST  = LW_W'(LDAC_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]    N_CH_V   = (CH_W+1)'(N_CH);

  typedef enum logic [2:0] {
    IDLE, ARB, SETUP, SHIFT, GAP, LDAC, ACK
  } state_e;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [DW-1:0]    data_q, data_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LW_W-1:0]  lw_q, lw_d;
  logic             phase_q, phase_d;
  logic             armed_q;

  logic             any_req;
  logic             div_end;
  logic             found;
  logic [CH_W-1:0]  pick;
  logic [CH_W:0]    idx;
  logic [CH_W-1:0]  cand;

  assign any_req = |bus.req;
  assign div_end = (div_q == DIV_LAST);

  // first requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (idx >= N_CH_V) idx = idx - N_CH_V;
      cand = idx[CH_W-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    bit_d   = bit_q;
    div_d   = div_q;
    lw_d    = lw_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && any_req) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          grant_d = pick;
          data_d  = bus.wr_data[int'(pick)*DW +: DW];
          ptr_d   = (pick == CH_LAST) ? '0 : pick + 1'b1;
          div_d   = '0;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      // phase 0 = sck high half, phase 1 = sck low half
      SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            data_d  = data_q << 1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) state_d = GAP;
            else bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_end) begin
          div_d   = '0;
          lw_d    = '0;
          state_d = LDAC;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LDAC: begin
        if (lw_q == LW_LAST) begin
          lw_d    = '0;
          state_d = ACK;
        end else begin
          lw_d = lw_q + 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ack    = '0;
    bus.sdi    = '0;
    bus.ldac   = '1;
    bus.busy   = 1'b0;
    bus.dac_cs = 1'b1;
    bus.sck    = 1'b0;
    unique case (state_q)
      ARB: bus.busy = found;
      SETUP: begin
        bus.busy         = 1'b1;
        bus.dac_cs       = 1'b0;
        bus.sdi[grant_q] = data_q[DW-1];
      end
      SHIFT: begin
        bus.busy         = 1'b1;
        bus.dac_cs       = 1'b0;
        bus.sck          = !phase_q;
        bus.sdi[grant_q] = data_q[DW-1];
      end
      GAP: bus.busy = 1'b1;
      LDAC: begin
        bus.busy          = 1'b1;
        bus.ldac[grant_q] = 1'b0;
      end
      ACK: begin
        bus.busy         = 1'b1;
        bus.ack[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // armed_q holds off arbitration for one edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      lw_q    <= '0;
      phase_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      lw_q    <= lw_d;
      phase_q <= phase_d;
      armed_q <= 1'b1;
    end
  end
endmodule
